// File: rtl/sel_seq_pkg.sv
// -----------------------------------------------------------------------------
// sel_seq_pkg
// Shared definitions for the select sequencer slice.
//   mode_e     : run-mode encodings driven on the sequencer's mode port
//   code_t     : 2-bit select code fed to the downstream 2x4 decoder
//   CODE_RESET : code presented out of reset
// -----------------------------------------------------------------------------
package sel_seq_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_UP   = 2'b01,
        MODE_DOWN = 2'b10,
        MODE_STEP = 2'b11
    } mode_e;

    typedef logic [1:0] code_t;

    localparam code_t CODE_RESET = 2'b00;

endpackage

// File: rtl/sel_prescaler.sv
// -----------------------------------------------------------------------------
// sel_prescaler
// Divides the clock for the run modes: tick is high on the cycle in which
// the sequencer should advance, once every div+1 enabled run cycles.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run enable; low clears the count
//   mode       : current mode
//   mode_q     : registered mode; a mismatch restarts the count
//   div        : divide value (0 = tick every enabled run cycle)
//   tick       : combinational advance strobe
// -----------------------------------------------------------------------------
module sel_prescaler
    import sel_seq_pkg::*;
#(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  mode_e                 mode,
    input  mode_e                 mode_q,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt;
    logic                  run_mode;
    logic                  restart;

    assign run_mode = (mode == MODE_UP) || (mode == MODE_DOWN);

    // Greater-or-equal rather than equality: if div is lowered below the
    // current count we tick immediately instead of waiting for a wrap.
    assign tick = en && run_mode && (cnt >= div);

    // Any mode change restarts the count so a new run starts from zero.
    assign restart = !en || !run_mode || (mode != mode_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/select_sequencer.sv
// -----------------------------------------------------------------------------
// select_sequencer
// Generates a registered 2-bit select code for a 2x4 decoder. The code runs
// up or down at a prescaled rate, or single-steps up on rising edges of step.
//
// Configuration macro
//   SELECT_SEQUENCER_GRAY_EN : when defined the code walks the Gray sequence
//                              00,01,11,10; otherwise binary 00,01,10,11.
//
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run enable; 0 freezes the code and clears the prescaler
//   mode       : 00 hold, 01 run up, 10 run down, 11 single-step up
//   step       : step request level (mode 11 only)
//   div        : run modes advance once every div+1 cycles
//   s1, s0     : registered select code, s1 is the MSB
//   adv        : one-cycle pulse in the cycle a new code first appears
//   wrap       : one-cycle pulse with adv when the code wraps
// -----------------------------------------------------------------------------
module select_sequencer
    import sel_seq_pkg::*;
#(
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic                  step,
    input  logic [PRESCALE_W-1:0] div,
    output logic                  s1,
    output logic                  s0,
    output logic                  adv,
    output logic                  wrap
);

    // Next code in the sequence for the given direction.
    function automatic code_t next_code(input code_t c, input logic up);
        code_t n;
`ifdef SELECT_SEQUENCER_GRAY_EN
        case (c)
            2'b00:   n = up ? 2'b01 : 2'b10;
            2'b01:   n = up ? 2'b11 : 2'b00;
            2'b11:   n = up ? 2'b10 : 2'b01;
            default: n = up ? 2'b00 : 2'b11;
        endcase
`else
        n = up ? c + 2'd1 : c - 2'd1;
`endif
        return n;
    endfunction

    // True when stepping from c in the given direction is the wrap move.
    function automatic logic is_wrap(input code_t c, input logic up);
        logic w;
`ifdef SELECT_SEQUENCER_GRAY_EN
        w = up ? (c == 2'b10) : (c == 2'b00);
`else
        w = up ? (c == 2'b11) : (c == 2'b00);
`endif
        return w;
    endfunction

    mode_e mode_cur;
    mode_e mode_q;
    logic  step_q;
    logic  tick;
    logic  step_adv;
    logic  adv_now;
    logic  dir_up;
    code_t code_q;

    assign mode_cur = mode_e'(mode);

    sel_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode_cur),
        .mode_q (mode_q),
        .div    (div),
        .tick   (tick)
    );

    // step_q tracks step in every mode so a level already high on entry to
    // step mode does not count as a fresh request.
    assign step_adv = en && (mode_cur == MODE_STEP) && step && !step_q;
    assign adv_now  = tick || step_adv;
    assign dir_up   = (mode_cur != MODE_DOWN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_HOLD;
            step_q <= 1'b0;
            code_q <= CODE_RESET;
            adv    <= 1'b0;
            wrap   <= 1'b0;
        end else begin
            mode_q <= mode_cur;
            step_q <= step;
            adv    <= adv_now;
            wrap   <= adv_now && is_wrap(code_q, dir_up);
            if (adv_now) begin
                code_q <= next_code(code_q, dir_up);
            end
        end
    end

    assign s1 = code_q[1];
    assign s0 = code_q[0];

endmodule

// File: tb/tb_select_sequencer.sv
// -----------------------------------------------------------------------------
// tb_select_sequencer
// Bench for select_sequencer: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a position-based model.
// -----------------------------------------------------------------------------
module tb_select_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       step = 1'b0;
    logic [3:0] div = 4'd0;
    logic       s1, s0, adv, wrap;

    int n_vec = 0;
    int n_err = 0;

    select_sequencer #(.PRESCALE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .mode  (mode),
        .step  (step),
        .div   (div),
        .s1    (s1),
        .s0    (s0),
        .adv   (adv),
        .wrap  (wrap)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helper ----------------
    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    // The code is tracked as a position 0..3 along the sequence; the
    // sequence table maps position to the visible code.
    function automatic logic [1:0] seq_code(input int p);
`ifdef SELECT_SEQUENCER_GRAY_EN
        case (p)
            0: return 2'b00;
            1: return 2'b01;
            2: return 2'b11;
            default: return 2'b10;
        endcase
`else
        return p[1:0];
`endif
    endfunction

    int   m_pos, m_cnt;
    logic [1:0] m_mode_q;
    logic m_step_q, m_adv, m_wrap;
    logic m_run, m_tick, m_step_go, m_go, m_up;

    assign m_run     = en && (mode == 2'b01 || mode == 2'b10);
    assign m_tick    = m_run && (m_cnt >= int'(div));
    assign m_step_go = en && (mode == 2'b11) && step && !m_step_q;
    assign m_go      = m_tick || m_step_go;
    assign m_up      = (mode != 2'b10);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pos    <= 0;
            m_cnt    <= 0;
            m_mode_q <= 2'b00;
            m_step_q <= 1'b0;
            m_adv    <= 1'b0;
            m_wrap   <= 1'b0;
        end else begin
            m_mode_q <= mode;
            m_step_q <= step;
            m_adv    <= m_go;
            m_wrap   <= m_go && (m_up ? (m_pos == 3) : (m_pos == 0));
            if (m_go) m_pos <= m_up ? (m_pos + 1) % 4 : (m_pos + 3) % 4;
            if (!m_run || (mode != m_mode_q) || m_tick) m_cnt <= 0;
            else m_cnt <= m_cnt + 1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("code", {s1, s0}, seq_code(m_pos));
        check("adv", adv, m_adv);
        check("wrap", wrap, m_wrap);
    end

    // ---------------- driver tasks ----------------
    logic [1:0] exp_q[$];
    logic [1:0] got_q[$];
    int         exp_cyc[$];
    int         got_cyc[$];
    int         wrap_cyc[$];

    // Apply one set of inputs for exactly one rising edge; returns at negedge.
    task automatic drive(input logic e, input logic [1:0] m, input logic st,
                         input logic [3:0] d);
        en = e; mode = m; step = st; div = d;
        @(negedge clk);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        en = 1'b0; mode = 2'b00; step = 1'b0; div = 4'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic clear_capture();
        exp_q.delete(); got_q.delete(); exp_cyc.delete();
        got_cyc.delete(); wrap_cyc.delete();
    endtask

    // Run n cycles with fixed inputs, logging advances (cycle numbers are
    // 1-based from the first call after clear, continuing via base).
    task automatic run_capture(input int n, input int base, input logic e,
                               input logic [1:0] m, input logic st,
                               input logic [3:0] d);
        for (int i = 1; i <= n; i++) begin
            drive(e, m, st, d);
            if (adv) begin
                got_q.push_back({s1, s0});
                got_cyc.push_back(base + i);
            end
            if (wrap) wrap_cyc.push_back(base + i);
        end
    endtask

    task automatic compare_capture(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({name, "_code"}, got_q[i], exp_q[i]);
        end
        for (int i = 0; i < exp_cyc.size() && i < got_cyc.size(); i++) begin
            check({name, "_cycle"}, got_cyc[i], exp_cyc[i]);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [1:0] held;
        int         n_pre;

        reset_dut();
        check("reset_code", {s1, s0}, 2'b00);
        check("reset_adv", adv, 1'b0);

        // Run up, div=2: the mode-change edge restarts the count, so the
        // first advance lands on edge 4 and then every 3 edges.
        clear_capture();
        run_capture(14, 0, 1'b1, 2'b01, 1'b0, 4'd2);
`ifdef SELECT_SEQUENCER_GRAY_EN
        exp_q = '{2'b01, 2'b11, 2'b10, 2'b00};
`else
        exp_q = '{2'b01, 2'b10, 2'b11, 2'b00};
`endif
        exp_cyc = '{4, 7, 10, 13};
        compare_capture("run_up");
        check("run_up_wrap_n", wrap_cyc.size(), 1);
        if (wrap_cyc.size() > 0) check("run_up_wrap_cyc", wrap_cyc[0], 13);

        // Run down, div=0: a new code every cycle, wrap on the first edge.
        reset_dut();
        clear_capture();
        run_capture(4, 0, 1'b1, 2'b10, 1'b0, 4'd0);
`ifdef SELECT_SEQUENCER_GRAY_EN
        exp_q = '{2'b10, 2'b11, 2'b01, 2'b00};
`else
        exp_q = '{2'b11, 2'b10, 2'b01, 2'b00};
`endif
        exp_cyc = '{1, 2, 3, 4};
        compare_capture("run_down");
        check("run_down_wrap_n", wrap_cyc.size(), 1);
        if (wrap_cyc.size() > 0) check("run_down_wrap_cyc", wrap_cyc[0], 1);

        // Single step: held level gives one advance, a fresh pulse another.
        reset_dut();
        clear_capture();
        run_capture(5, 0, 1'b1, 2'b11, 1'b1, 4'd0);
        run_capture(1, 5, 1'b1, 2'b11, 1'b0, 4'd0);
        run_capture(1, 6, 1'b1, 2'b11, 1'b1, 4'd0);
        run_capture(2, 7, 1'b1, 2'b11, 1'b0, 4'd0);
`ifdef SELECT_SEQUENCER_GRAY_EN
        exp_q = '{2'b01, 2'b11};
`else
        exp_q = '{2'b01, 2'b10};
`endif
        exp_cyc = '{1, 7};
        compare_capture("step");

        // Div shrink: six edges at div=7 leave the count at 5; lowering div
        // to 2 advances on the very next edge, then every 3.
        reset_dut();
        clear_capture();
        run_capture(6, 0, 1'b1, 2'b01, 1'b0, 4'd7);
        run_capture(7, 6, 1'b1, 2'b01, 1'b0, 4'd2);
`ifdef SELECT_SEQUENCER_GRAY_EN
        exp_q = '{2'b01, 2'b11, 2'b10};
`else
        exp_q = '{2'b01, 2'b10, 2'b11};
`endif
        exp_cyc = '{7, 10, 13};
        compare_capture("div_shrink");

        // Hold mode then disable: code frozen, no advances. Resuming from
        // en=0 with the mode unchanged advances div+1 cycles later.
        held = {s1, s0};
        clear_capture();
        run_capture(10, 0, 1'b1, 2'b00, 1'b0, 4'd2);
        run_capture(10, 10, 1'b0, 2'b01, 1'b0, 4'd2);
        check("hold_adv_n", got_q.size(), 0);
        check("hold_code", {s1, s0}, held);
        clear_capture();
        run_capture(3, 0, 1'b1, 2'b01, 1'b0, 4'd2);
        exp_q = '{seq_code(0)};
        exp_cyc = '{3};
        compare_capture("resume");

        // Asynchronous reset mid-run with code 10, checked between edges.
        reset_dut();
`ifdef SELECT_SEQUENCER_GRAY_EN
        n_pre = 3;
`else
        n_pre = 2;
`endif
        repeat (n_pre) drive(1'b1, 2'b01, 1'b0, 4'd0);
        check("pre_reset_code", {s1, s0}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("async_code", {s1, s0}, 2'b00);
        check("async_adv", adv, 1'b0);
        check("async_wrap", wrap, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // First run advance after reset, div=1: mode-change edge, then 2 more.
        clear_capture();
        run_capture(3, 0, 1'b1, 2'b01, 1'b0, 4'd1);
        exp_q = '{2'b01};
        exp_cyc = '{3};
        compare_capture("post_reset");

        // Randomized run, checked each cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            logic       e, st;
            logic [1:0] m;
            logic [3:0] d;
            e  = ($urandom_range(0, 9) != 0);
            m  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : mode;
            st = ($urandom_range(0, 2) == 0) ? ~step : step;
            d  = div;
            if ($urandom_range(0, 15) == 0)
                d = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                : 4'($urandom_range(0, 4));
            if ($urandom_range(0, 399) == 0) begin
                #($urandom_range(1, 4)) rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            drive(e, m, st, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
